// File: rtl/nx_msg_arbiter.sv
// nx_msg_arbiter
// ---------------------------------------------------------------------------
// Output-side scheduler for a node's message network. Two message streams,
// bypass (forwarded/broadcast traffic from the decoder) and emit (locally
// generated signal-state messages), are merged onto four registered
// outbound links N/E/S/W (0..3). Each message is routed by its 2-bit
// direction field. When both sources target the same link in the same
// cycle, a per-link round-robin pointer chooses the winner.
//
// Handshake: a word moves on any channel in a cycle where valid && ready
// are both high at the rising edge. A source that is valid but not ready
// must hold data and dir stable; the arbiter keeps no copy of rejected
// requests. Ready outputs are combinational from valid, dir and
// outbound_ready_i.
//
// Optional build macro: NX_MSG_ARB_BYPASS_PRIO_EN
//   defined   -> fixed priority, bypass always wins contention, no pointers
//   undefined -> per-link round-robin (default)
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   idle_o                no input valid and no outbound word pending
//   bypass_*_i / _o       bypass stream: data, dir, valid, ready
//   emit_*_i / _o         emit stream:   data, dir, valid, ready
//   outbound_data_o       link d at [d*STREAM_WIDTH +: STREAM_WIDTH]
//   outbound_valid_o      per-link valid
//   outbound_ready_i      per-link ready from the neighbour
// ---------------------------------------------------------------------------
module nx_msg_arbiter #(
  parameter int STREAM_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      idle_o,
  input  logic [STREAM_WIDTH-1:0]   bypass_data_i,
  input  logic [1:0]                bypass_dir_i,
  input  logic                      bypass_valid_i,
  output logic                      bypass_ready_o,
  input  logic [STREAM_WIDTH-1:0]   emit_data_i,
  input  logic [1:0]                emit_dir_i,
  input  logic                      emit_valid_i,
  output logic                      emit_ready_o,
  output logic [4*STREAM_WIDTH-1:0] outbound_data_o,
  output logic [3:0]                outbound_valid_o,
  input  logic [3:0]                outbound_ready_i
);

  logic [STREAM_WIDTH-1:0] data_q [4];
  logic [STREAM_WIDTH-1:0] data_d [4];
  logic [3:0]              valid_q, valid_d;
  logic [3:0]              link_free;
  logic [3:0]              req_byp, req_emt;
  logic [3:0]              gnt_byp, gnt_emt;

`ifndef NX_MSG_ARB_BYPASS_PRIO_EN
  // last_q[d]: source that last won link d (0 = bypass, 1 = emit).
  logic [3:0]              last_q, last_d;
`endif

  always_comb begin
    link_free = '0;
    req_byp   = '0;
    req_emt   = '0;
    gnt_byp   = '0;
    gnt_emt   = '0;
    for (int d = 0; d < 4; d++) begin
      // Same-cycle drain: a link whose word is being taken can refill now.
      link_free[d] = !valid_q[d] || outbound_ready_i[d];
      req_byp[d]   = bypass_valid_i && (bypass_dir_i == 2'(d));
      req_emt[d]   = emit_valid_i && (emit_dir_i == 2'(d));
`ifdef NX_MSG_ARB_BYPASS_PRIO_EN
      gnt_byp[d]   = link_free[d] && req_byp[d];
      gnt_emt[d]   = link_free[d] && req_emt[d] && !req_byp[d];
`else
      // On contention the source that did not win last time goes first.
      gnt_byp[d]   = link_free[d] && req_byp[d] && (!req_emt[d] || last_q[d]);
      gnt_emt[d]   = link_free[d] && req_emt[d] && (!req_byp[d] || !last_q[d]);
`endif
    end
  end

  // Each source targets exactly one link, so at most one bit can be set.
  assign bypass_ready_o = |gnt_byp;
  assign emit_ready_o   = |gnt_emt;

  always_comb begin
    valid_d = valid_q;
    for (int d = 0; d < 4; d++) begin
      data_d[d] = data_q[d];
      if (gnt_byp[d]) begin
        data_d[d]  = bypass_data_i;
        valid_d[d] = 1'b1;
      end else if (gnt_emt[d]) begin
        data_d[d]  = emit_data_i;
        valid_d[d] = 1'b1;
      end else if (outbound_ready_i[d]) begin
        valid_d[d] = 1'b0;
      end
    end
  end

`ifndef NX_MSG_ARB_BYPASS_PRIO_EN
  always_comb begin
    last_d = last_q;
    for (int d = 0; d < 4; d++) begin
      if (gnt_byp[d]) begin
        last_d[d] = 1'b0;
      end else if (gnt_emt[d]) begin
        last_d[d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 4'hF;   // emit "last won" so bypass takes the first contention
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int d = 0; d < 4; d++) begin
        data_q[d] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int d = 0; d < 4; d++) begin
        data_q[d] <= data_d[d];
      end
    end
  end

  always_comb begin
    outbound_data_o = '0;
    for (int d = 0; d < 4; d++) begin
      outbound_data_o[d*STREAM_WIDTH +: STREAM_WIDTH] = data_q[d];
    end
  end

  assign outbound_valid_o = valid_q;
  assign idle_o = !bypass_valid_i && !emit_valid_i && !(|valid_q);

endmodule

// File: tb/tb_nx_msg_arbiter.sv
// Directed testbench for nx_msg_arbiter. Inputs change 1 time unit after a
// rising edge; combinational readys are checked 1 unit later, registered
// outputs 1 unit after the following edge.
module tb_nx_msg_arbiter;
  localparam int W = 32;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           idle;
  logic [W-1:0]   byp_data, emt_data;
  logic [1:0]     byp_dir, emt_dir;
  logic           byp_valid, emt_valid, byp_ready, emt_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid, out_ready;

  nx_msg_arbiter #(.STREAM_WIDTH(W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .idle_o           (idle),
    .bypass_data_i    (byp_data),
    .bypass_dir_i     (byp_dir),
    .bypass_valid_i   (byp_valid),
    .bypass_ready_o   (byp_ready),
    .emit_data_i      (emt_data),
    .emit_dir_i       (emt_dir),
    .emit_valid_i     (emt_valid),
    .emit_ready_o     (emt_ready),
    .outbound_data_o  (out_data),
    .outbound_valid_o (out_valid),
    .outbound_ready_i (out_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [W-1:0] link(input int k);
    return out_data[k*W +: W];
  endfunction

  // ---- checker ----
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef NX_MSG_ARB_BYPASS_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  initial begin
    logic [W-1:0] byp_words [4];
    logic [W-1:0] emt_words [4];
    int bi, ei;
    logic exp_b;

    byp_words[0] = 32'hB000_0000; byp_words[1] = 32'hB000_0001;
    byp_words[2] = 32'hB000_0002; byp_words[3] = 32'hB000_0003;
    emt_words[0] = 32'hE000_0000; emt_words[1] = 32'hE000_0001;
    emt_words[2] = 32'hE000_0002; emt_words[3] = 32'hE000_0003;

    // ---- reset then idle ----
    rst = 1'b1; byp_data = '0; byp_dir = '0; byp_valid = 1'b0;
    emt_data = '0; emt_dir = '0; emt_valid = 1'b0; out_ready = 4'h0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_valid", 128'(out_valid), 128'(4'b0000));
    chk("rst_data",  128'(out_data),  128'(0));
    chk("rst_byp_rdy", 128'(byp_ready), 128'(1'b0));
    chk("rst_emt_rdy", 128'(emt_ready), 128'(1'b0));
    chk("rst_idle",  128'(idle), 128'(1'b1));

    // ---- parallel routing: bypass -> E(1), emit -> W(3) ----
    out_ready = 4'hF;
    byp_data = 32'hAAAA_0001; byp_dir = 2'd1; byp_valid = 1'b1;
    emt_data = 32'h5555_0002; emt_dir = 2'd3; emt_valid = 1'b1;
    settle();
    chk("par_byp_rdy", 128'(byp_ready), 128'(1'b1));
    chk("par_emt_rdy", 128'(emt_ready), 128'(1'b1));
    chk("par_idle",    128'(idle), 128'(1'b0));
    tick();
    byp_valid = 1'b0; emt_valid = 1'b0;
    chk("par_valid", 128'(out_valid), 128'(4'b1010));
    chk("par_link1", 128'(link(1)), 128'(32'hAAAA_0001));
    chk("par_link3", 128'(link(3)), 128'(32'h5555_0002));

    // ---- contention on S(2): round-robin (or bypass-only in prio build) ----
    bi = 0; ei = 0;
    byp_dir = 2'd2; emt_dir = 2'd2;
    byp_valid = 1'b1; emt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      byp_data = byp_words[bi]; emt_data = emt_words[ei];
      settle();
      exp_b = PRIO ? 1'b1 : ((i % 2) == 0);
      chk("cont_byp_rdy", 128'(byp_ready), 128'(exp_b));
      chk("cont_emt_rdy", 128'(emt_ready), 128'(!exp_b));
      tick();
      chk("cont_valid", 128'(out_valid), 128'(4'b0100));
      if (exp_b) begin
        chk("cont_link2", 128'(link(2)), 128'(byp_words[bi]));
        bi++;
      end else begin
        chk("cont_link2", 128'(link(2)), 128'(emt_words[ei]));
        ei++;
      end
    end
    // Bypass withdraws: emit takes the link next.
    byp_valid = 1'b0; emt_data = emt_words[ei];
    settle();
    chk("solo_emt_rdy", 128'(emt_ready), 128'(1'b1));
    tick();
    emt_valid = 1'b0;
    chk("solo_link2", 128'(link(2)), 128'(emt_words[ei]));
    chk("solo_valid", 128'(out_valid), 128'(4'b0100));

    // ---- backpressure on N(0) ----
    out_ready = 4'b1110;
    byp_dir = 2'd0; byp_valid = 1'b1; byp_data = 32'hC0DE_0000;
    settle();
    chk("bp_rdy0", 128'(byp_ready), 128'(1'b1));
    tick();
    chk("bp_word0", 128'(link(0)), 128'(32'hC0DE_0000));
    chk("bp_valid0", 128'(out_valid), 128'(4'b0001));
    byp_data = 32'hC0DE_0001;
    settle();
    chk("bp_stall_rdy", 128'(byp_ready), 128'(1'b0));
    tick(); tick();
    chk("bp_hold_data",  128'(link(0)), 128'(32'hC0DE_0000));
    chk("bp_hold_valid", 128'(out_valid[0]), 128'(1'b1));
    out_ready = 4'hF;
    settle();
    chk("bp_drain_rdy", 128'(byp_ready), 128'(1'b1));
    tick();
    chk("bp_word1", 128'(link(0)), 128'(32'hC0DE_0001));
    byp_data = 32'hC0DE_0002;
    settle();
    chk("bp_rdy2", 128'(byp_ready), 128'(1'b1));
    tick();
    byp_valid = 1'b0;
    chk("bp_word2", 128'(link(0)), 128'(32'hC0DE_0002));
    chk("bp_valid2", 128'(out_valid[0]), 128'(1'b1));
    tick();
    chk("bp_empty", 128'(out_valid), 128'(4'b0000));
    chk("bp_idle",  128'(idle), 128'(1'b1));

    // ---- reset mid-operation: links 0 and 2 stuck with ready low ----
    // Uncontested bypass on S leaves its pointer at "bypass last".
    out_ready = 4'h0;
    byp_dir = 2'd2; byp_data = 32'hDEAD_0002; byp_valid = 1'b1;
    emt_dir = 2'd0; emt_data = 32'hDEAD_0000; emt_valid = 1'b1;
    tick();
    byp_valid = 1'b0; emt_valid = 1'b0;
    chk("mid_valid", 128'(out_valid), 128'(4'b0101));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 128'(out_valid), 128'(4'b0000));
    chk("mid_rst_data",  128'(out_data),  128'(0));
    out_ready = 4'hF;
    byp_dir = 2'd2; emt_dir = 2'd2; byp_valid = 1'b1; emt_valid = 1'b1;
    byp_data = 32'h1111_0000; emt_data = 32'h2222_0000;
    settle();
    chk("post_rst_byp_rdy", 128'(byp_ready), 128'(1'b1));
    chk("post_rst_emt_rdy", 128'(emt_ready), 128'(1'b0));
    tick();
    byp_valid = 1'b0; emt_valid = 1'b0;
    chk("post_rst_link2", 128'(link(2)), 128'(32'h1111_0000));
    tick();
    chk("final_idle", 128'(idle), 128'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
